// File: rtl/prga_decrypt.sv
// RC4 keystream generation and message decryption over shared S memory.
// One keystream byte per message byte; optional abort on non-text output.
module prga_decrypt #(
    parameter int MSG_LEN     = 32,
    parameter bit CHECK_CHARS = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       finish,
    output logic       key_invalid,
    output logic [7:0] s_address,
    input  logic [7:0] s_data_in,
    output logic [7:0] s_data_out,
    output logic       s_write_enable,
    output logic [4:0] rom_address,
    input  logic [7:0] rom_data,
    output logic [4:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_write_enable
);

    typedef enum logic [3:0] {
        IDLE, RD_SI, LATCH_SI, CALC_J, RD_SJ, LATCH_SJ,
        WR_I, WR_J, RD_F, LATCH_F, WR_DEC, NEXT, DONE
    } state_e;

    localparam logic [4:0] LAST = 5'(MSG_LEN - 1);

    state_e     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d;
    logic [4:0] k_q, k_d;
    logic [7:0] si_q, si_d, sj_q, sj_d;
    logic [7:0] f_q, f_d, enc_q, enc_d;
    logic [7:0] s_address_q, s_address_d;
    logic [7:0] s_data_out_q, s_data_out_d;
    logic       s_we_q, s_we_d;
    logic [4:0] rom_address_q, rom_address_d;
    logic [4:0] dec_address_q, dec_address_d;
    logic [7:0] dec_data_q, dec_data_d;
    logic       dec_we_q, dec_we_d;
    logic       finish_q, finish_d;
    logic       key_invalid_q, key_invalid_d;

    function automatic logic is_text(input logic [7:0] c);
        return (c == 8'h20) || (c >= 8'h61 && c <= 8'h7a);
    endfunction

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        si_d          = si_q;
        sj_d          = sj_q;
        f_d           = f_q;
        enc_d         = enc_q;
        key_invalid_d = key_invalid_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    i_d           = 8'd1;
                    j_d           = 8'd0;
                    k_d           = 5'd0;
                    key_invalid_d = 1'b0;
                    state_d       = RD_SI;
                end
            end
            RD_SI:    state_d = LATCH_SI;
            LATCH_SI: begin
                si_d    = s_data_in;
                state_d = CALC_J;
            end
            CALC_J: begin
                j_d     = j_q + si_q;
                state_d = RD_SJ;
            end
            RD_SJ:    state_d = LATCH_SJ;
            LATCH_SJ: begin
                sj_d    = s_data_in;
                state_d = WR_I;
            end
            WR_I:     state_d = WR_J;
            WR_J:     state_d = RD_F;
            RD_F:     state_d = LATCH_F;
            LATCH_F: begin
                f_d     = s_data_in;
                enc_d   = rom_data;
                state_d = WR_DEC;
            end
            WR_DEC: begin
                if (CHECK_CHARS && !is_text(dec_data_q))
                    key_invalid_d = 1'b1;
                state_d = NEXT;
            end
            NEXT: begin
                if (key_invalid_q || k_q == LAST) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = k_q + 5'd1;
                    state_d = RD_SI;
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are registered: load the values the next state presents.
    always_comb begin
        s_address_d   = s_address_q;
        s_data_out_d  = s_data_out_q;
        rom_address_d = rom_address_q;
        dec_address_d = dec_address_q;
        dec_data_d    = dec_data_q;
        s_we_d        = 1'b0;
        dec_we_d      = 1'b0;
        finish_d      = 1'b0;
        unique case (state_d)
            RD_SI, LATCH_SI: s_address_d = i_d;
            RD_SJ, LATCH_SJ: s_address_d = j_d;
            WR_I: begin
                s_address_d  = i_d;
                s_data_out_d = sj_d;
                s_we_d       = 1'b1;
            end
            WR_J: begin
                s_address_d  = j_d;
                s_data_out_d = si_d;
                s_we_d       = 1'b1;
            end
            RD_F, LATCH_F: begin
                s_address_d   = si_d + sj_d;
                rom_address_d = k_d;
            end
            WR_DEC: begin
                dec_address_d = k_d;
                dec_data_d    = f_d ^ enc_d;
                dec_we_d      = 1'b1;
            end
            DONE:    finish_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            si_q          <= '0;
            sj_q          <= '0;
            f_q           <= '0;
            enc_q         <= '0;
            s_address_q   <= '0;
            s_data_out_q  <= '0;
            s_we_q        <= 1'b0;
            rom_address_q <= '0;
            dec_address_q <= '0;
            dec_data_q    <= '0;
            dec_we_q      <= 1'b0;
            finish_q      <= 1'b0;
            key_invalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            si_q          <= si_d;
            sj_q          <= sj_d;
            f_q           <= f_d;
            enc_q         <= enc_d;
            s_address_q   <= s_address_d;
            s_data_out_q  <= s_data_out_d;
            s_we_q        <= s_we_d;
            rom_address_q <= rom_address_d;
            dec_address_q <= dec_address_d;
            dec_data_q    <= dec_data_d;
            dec_we_q      <= dec_we_d;
            finish_q      <= finish_d;
            key_invalid_q <= key_invalid_d;
        end
    end

    assign s_address        = s_address_q;
    assign s_data_out       = s_data_out_q;
    assign s_write_enable   = s_we_q;
    assign rom_address      = rom_address_q;
    assign dec_address      = dec_address_q;
    assign dec_data         = dec_data_q;
    assign dec_write_enable = dec_we_q;
    assign finish           = finish_q;
    assign key_invalid      = key_invalid_q;

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: two instances (3-byte no-check, 32-byte check)
// driven against an array-level RC4 reference model.
module tb_prga_decrypt;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start   [2];
    logic       fin     [2];
    logic       kinv    [2];
    logic       s_we    [2];
    logic       dec_we  [2];
    logic [7:0] s_addr  [2];
    logic [7:0] s_wd    [2];
    logic [7:0] s_rd    [2];
    logic [7:0] rom_rd  [2];
    logic [7:0] dec_d   [2];
    logic [4:0] rom_a   [2];
    logic [4:0] dec_a   [2];

    always #5 clock = ~clock;

    prga_decrypt #(.MSG_LEN(3), .CHECK_CHARS(1'b0)) u_a (
        .clock(clock), .reset(reset), .start(start[0]),
        .finish(fin[0]), .key_invalid(kinv[0]),
        .s_address(s_addr[0]), .s_data_in(s_rd[0]),
        .s_data_out(s_wd[0]), .s_write_enable(s_we[0]),
        .rom_address(rom_a[0]), .rom_data(rom_rd[0]),
        .dec_address(dec_a[0]), .dec_data(dec_d[0]),
        .dec_write_enable(dec_we[0])
    );

    prga_decrypt #(.MSG_LEN(32), .CHECK_CHARS(1'b1)) u_b (
        .clock(clock), .reset(reset), .start(start[1]),
        .finish(fin[1]), .key_invalid(kinv[1]),
        .s_address(s_addr[1]), .s_data_in(s_rd[1]),
        .s_data_out(s_wd[1]), .s_write_enable(s_we[1]),
        .rom_address(rom_a[1]), .rom_data(rom_rd[1]),
        .dec_address(dec_a[1]), .dec_data(dec_d[1]),
        .dec_write_enable(dec_we[1])
    );

    logic [7:0] s_mem   [2][256];
    logic [7:0] rom     [2][32];
    logic [7:0] dec_mem [2][32];
    logic [7:0] s_init  [256];
    logic [7:0] enc     [32];
    logic [7:0] ms      [256];
    logic [7:0] mdec    [32];
    int         mn;
    bit         minv;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         fin_cyc, fin_cnt, wr_cnt, sw_cnt;
    logic [7:0] sw_a [2];
    logic [7:0] sw_d [2];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_text(input logic [7:0] c);
        return (c == 8'h20) || (c >= 8'h61 && c <= 8'h7a);
    endfunction

    function automatic logic nz(input int d);
        return |{fin[d], kinv[d], s_we[d], dec_we[d], s_addr[d],
                 s_wd[d], rom_a[d], dec_a[d], dec_d[d]};
    endfunction

    // Plain RC4 PRGA over ms[] and enc[]
    task automatic model(input int len, input bit chk);
        int i = 0;
        int j = 0;
        logic [7:0] t;
        logic [7:0] f;
        mn   = 0;
        minv = 0;
        for (int k = 0; k < len; k++) begin
            i = (i + 1) % 256;
            j = (j + ms[i]) % 256;
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
            f = ms[(int'(ms[i]) + int'(ms[j])) % 256];
            mdec[k] = f ^ enc[k];
            mn = k + 1;
            if (chk && !is_text(mdec[k])) begin
                minv = 1;
                break;
            end
        end
    endtask

    task automatic load(input int d, input int len, input bit chk);
        for (int x = 0; x < 256; x++) begin
            s_mem[d][x] = s_init[x];
            ms[x]       = s_init[x];
        end
        for (int x = 0; x < 32; x++) begin
            rom[d][x]     = enc[x];
            dec_mem[d][x] = 8'hee;
        end
        model(len, chk);
    endtask

    task automatic mem_step(input int d);
        s_rd[d]   <= s_mem[d][s_addr[d]];
        rom_rd[d] <= rom[d][rom_a[d]];
        if (s_we[d])   s_mem[d][s_addr[d]] <= s_wd[d];
        if (dec_we[d]) dec_mem[d][dec_a[d]] <= dec_d[d];
    endtask

    task automatic run(input int d, input int pulse_at, input int rst_at);
        fin_cyc = 0; fin_cnt = 0; wr_cnt = 0; sw_cnt = 0;
        @(negedge clock);
        start[d] = 1'b1;
        @(posedge clock);
        mem_step(d);
        #1 start[d] = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clock);
            if (fin[d]) begin
                fin_cnt++;
                if (fin_cyc == 0) fin_cyc = n;
            end
            if (dec_we[d]) wr_cnt++;
            if (s_we[d]) begin
                if (sw_cnt < 2) begin
                    sw_a[sw_cnt] = s_addr[d];
                    sw_d[sw_cnt] = s_wd[d];
                end
                sw_cnt++;
            end
            start[d] = (n == pulse_at);
            if (n == rst_at) begin
                reset = 1'b0;
                #1;
                check("rst_mid_a_zero", int'(nz(0)), 0);
                check("rst_mid_b_zero", int'(nz(1)), 0);
                repeat (2) @(negedge clock);
                check("rst_hold_no_fin", fin_cnt + int'(fin[d]), 0);
                reset = 1'b1;
                return;
            end
            if (fin_cyc != 0 && n >= fin_cyc + 3) break;
            @(posedge clock);
            mem_step(d);
        end
    endtask

    task automatic verify(input int d, input int len, input string tag);
        int bad = 0;
        check({tag, "_fin_cyc"}, fin_cyc, 11 * mn + 1);
        check({tag, "_fin_width"}, fin_cnt, 1);
        check({tag, "_key_invalid"}, int'(kinv[d]), int'(minv));
        check({tag, "_writes"}, wr_cnt, mn);
        for (int k = 0; k < len; k++)
            check($sformatf("%s_dec%0d", tag, k), dec_mem[d][k],
                  (k < mn) ? mdec[k] : 8'hee);
        for (int x = 0; x < 256; x++)
            if (s_mem[d][x] !== ms[x]) bad++;
        check({tag, "_s_final"}, bad, 0);
    endtask

    task automatic rand_perm();
        logic [7:0] t;
        int r;
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(0, x);
            t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
        end
    endtask

    // ROM that decrypts to random valid text under the current s_init
    task automatic text_rom();
        int r;
        for (int x = 0; x < 256; x++) ms[x] = s_init[x];
        for (int x = 0; x < 32; x++) enc[x] = 8'h00;
        model(32, 1'b0);
        for (int x = 0; x < 32; x++) begin
            r = $urandom_range(0, 26);
            enc[x] = mdec[x] ^ ((r == 26) ? 8'h20 : 8'(8'h61 + r));
        end
    endtask

    task automatic identity_a();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int x = 0; x < 32; x++) enc[x] = 8'h00;
        load(0, 3, 1'b0);
        run(0, 0, 0);
        verify(0, 3, "id3");
        check("id3_dec0", dec_mem[0][0], 8'h02);
        check("id3_dec1", dec_mem[0][1], 8'h05);
        check("id3_dec2", dec_mem[0][2], 8'h07);
        check("id3_s1", s_mem[0][1], 8'h01);
        check("id3_s2", s_mem[0][2], 8'h03);
        check("id3_s3", s_mem[0][3], 8'h05);
        check("id3_s5", s_mem[0][5], 8'h02);
        check("id3_fin34", fin_cyc, 34);
        check("id3_kinv", int'(kinv[0]), 0);
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        s_rd[0] = '0; s_rd[1] = '0;
        rom_rd[0] = '0; rom_rd[1] = '0;
        repeat (3) @(negedge clock);
        check("reset_a_zero", int'(nz(0)), 0);
        check("reset_b_zero", int'(nz(1)), 0);
        reset = 1'b1;
        @(negedge clock);

        identity_a();
        check("swap0_addr_i", sw_a[0], 8'h01);
        check("swap0_data_i", sw_d[0], 8'h01);
        check("swap0_addr_j", sw_a[1], 8'h01);
        check("swap0_data_j", sw_d[1], 8'h01);

        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int x = 0; x < 32; x++) enc[x] = 8'($urandom);
        enc[0] = 8'h63; enc[1] = 8'h25; enc[2] = 8'h07;
        load(1, 32, 1'b1);
        run(1, 0, 0);
        verify(1, 32, "abort");
        check("abort_dec0", dec_mem[1][0], 8'h61);
        check("abort_dec1", dec_mem[1][1], 8'h20);
        check("abort_dec2", dec_mem[1][2], 8'h00);
        check("abort_kinv", int'(kinv[1]), 1);
        check("abort_fin34", fin_cyc, 34);
        check("abort_no_dec3", dec_mem[1][3], 8'hee);

        rand_perm();
        text_rom();
        load(1, 32, 1'b1);
        run(1, 50, 0);
        verify(1, 32, "text");
        check("text_fin353", fin_cyc, 353);
        check("text_writes32", wr_cnt, 32);

        for (int t = 0; t < 4; t++) begin
            rand_perm();
            for (int x = 0; x < 32; x++) enc[x] = 8'($urandom);
            load(0, 3, 1'b0);
            run(0, 0, 0);
            verify(0, 3, $sformatf("rnd_a%0d", t));
        end
        for (int t = 0; t < 3; t++) begin
            rand_perm();
            if (t == 1) text_rom();
            else for (int x = 0; x < 32; x++) enc[x] = 8'($urandom);
            load(1, 32, 1'b1);
            run(1, 0, 0);
            verify(1, 32, $sformatf("rnd_b%0d", t));
        end

        rand_perm();
        text_rom();
        load(1, 32, 1'b1);
        run(1, 0, 100);
        @(negedge clock);
        identity_a();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prga_decrypt.md
# prga_decrypt

Keystream generation and decryption stage of the RC4 datapath. Starts after the key-scheduling swap pass has permuted the shared 256-byte S memory. It re-reads and swaps S entries to produce one keystream byte per message byte, XORs each with the encrypted-message ROM, and writes the result to the decrypted-message RAM. An optional character check aborts on the first non-text byte so a key-search master can move to the next key.

## Interface
- `MSG_LEN`, 32: message length in bytes, 1..32.
- `CHECK_CHARS`, 1: 1 = abort on a byte outside {0x20, 0x61..0x7A}; 0 = decrypt all bytes.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: level, sampled only in IDLE.
- `finish` out 1: one-cycle pulse in DONE.
- `key_invalid` out 1: sticky abort flag; cleared when a start is accepted.
- `s_address` out 8: S memory address.
- `s_data_in` in 8: S read data.
- `s_data_out` out 8: S write data.
- `s_write_enable` out 1: S write strobe.
- `rom_address` out 5: encrypted ROM address.
- `rom_data` in 8: encrypted ROM data.
- `dec_address` out 5: decrypted RAM address.
- `dec_data` out 8: decrypted RAM write data.
- `dec_write_enable` out 1: decrypted RAM write strobe.

## Operation
- Algorithm: i=0, j=0. For k=0..MSG_LEN-1:
  - i=i+1; j=j+s[i]
  - swap s[i], s[j]
  - f=s[s[i]+s[j]]
  - dec[k]=f^enc[k]
- All index arithmetic is 8-bit, wrapping mod 256.
- Registers:
  - i: 8 bit, loaded 1 on start accept.
  - j: 8 bit, loaded 0 on start accept.
  - k: 5 bit, loaded 0 on start accept.
  - si, sj, f, enc: 8 bit each.
- Memory read model: the address driven in cycle N is registered by the memory at the end of cycle N; data is sampled from `s_data_in` / `rom_data` at the end of cycle N+1.
- States, one cycle each, in this order:
  - IDLE: all strobes 0. If `start` is high, load i/j/k, clear `key_invalid`, go to RD_SI.
  - RD_SI: s_address=i.
  - LATCH_SI: s_address=i; si<=s_data_in.
  - CALC_J: j<=j+si.
  - RD_SJ: s_address=j.
  - LATCH_SJ: s_address=j; sj<=s_data_in.
  - WR_I: s_address=i, s_data_out=sj, s_write_enable=1.
  - WR_J: s_address=j, s_data_out=si, s_write_enable=1.
  - RD_F: s_address=si+sj; rom_address=k.
  - LATCH_F: same addresses as RD_F; f<=s_data_in, enc<=rom_data.
  - WR_DEC: dec_address=k, dec_data=f^enc, dec_write_enable=1. If CHECK_CHARS=1 and f^enc is not in {0x20, 0x61..0x7A}, set `key_invalid`.
  - NEXT: if `key_invalid`, or k==MSG_LEN-1, go to DONE; else i<=i+1, k<=k+1, go to RD_SI.
  - DONE: finish=1, then go to IDLE.
- The f address uses the pre-swap si+sj. That sum equals the post-swap s[i]+s[j], so no re-read is needed.
- i==j: both writes hit the same address with the same value; S is unchanged.
- `start` outside IDLE is ignored. Holding `start` high through DONE restarts on the next IDLE cycle.
- An invalid byte is still written to dec RAM; no later bytes are written.
- Address and data outputs not listed for a state hold their previous value. Strobes are 0 in every state not listed.

## Timing
- Reset (asynchronous, low): state=IDLE; all outputs 0; i, j, k, si, sj, f, enc = 0. Memory contents are not restored. On release, the block waits for `start`.
- Reset mid-operation aborts immediately. No `finish` pulse is produced.
- 11 cycles per byte. Counting cycle 1 as the first cycle after the edge that accepts `start`, byte b occupies cycles 11b+1..11b+11.
- `finish` is high in cycle 11·n+1, where n = bytes processed (MSG_LEN, or the aborting byte index +1).
- MSG_LEN=32 with no abort: `finish` at cycle 353.

## Test plan
- Identity S (s[x]=x), ROM all 0x00, CHECK_CHARS=0, MSG_LEN=3 -> dec = 0x02, 0x05, 0x07. After finish: s[1]=1, s[2]=3, s[3]=5, s[5]=2. `finish` in cycle 34, `key_invalid`=0.
- Same S and settings; observe the byte-0 swap -> i=j=1, two writes of 0x01 to address 1, S unchanged.
- Identity S, CHECK_CHARS=1, MSG_LEN=32, ROM = 0x63, 0x25, 0x07, ... -> dec = 0x61, 0x20, 0x00. `key_invalid`=1, `finish` in cycle 34, no write to dec address 3.
- MSG_LEN=32, ROM chosen to give all-valid text -> exactly 32 dec writes, `finish` one cycle wide in cycle 353, `key_invalid`=0.
- Pulse `start` again at cycle 50 of a run -> ignored; `finish` timing unchanged.
- Drive `reset` low at cycle 100 -> all outputs 0 in the same cycle, state IDLE. A new start with identity S reloaded reproduces the first scenario's results.
